// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU controller: FSM state encodings,
// opcode and ALU-operation constants, and the bundled control-strobe record.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        logic legal;
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Moore output decode: maps the current state and latched opcode to datapath
// strobes. alu_zero only qualifies pc_write for a branch in EXEC.
module ctrl_output_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [6:0] i_opcode,
    input  logic       i_alu_zero,
    output ctrl_t      o_ctrl
);

    logic       w_alu_src;
    logic [1:0] w_alu_op;

    always_comb begin
        w_alu_src = 1'b0;
        w_alu_op  = ALUOP_ADD;
        case (i_opcode)
            OP_R: begin
                w_alu_src = 1'b0;
                w_alu_op  = ALUOP_RTYPE;
            end
            OP_IMM: begin
                w_alu_src = 1'b1;
                w_alu_op  = ALUOP_ITYPE;
            end
            OP_LOAD, OP_STORE: begin
                w_alu_src = 1'b1;
                w_alu_op  = ALUOP_ADD;
            end
            OP_BRANCH: begin
                w_alu_src = 1'b0;
                w_alu_op  = ALUOP_SUB;
            end
            default: ;
        endcase
    end

    // ALU selects stay stable from EXEC through WB so the result path is held.
    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.ir_write = 1'b1;
                o_ctrl.pc_write = 1'b1;
            end
            ST_EXEC: begin
                o_ctrl.alu_src = w_alu_src;
                o_ctrl.alu_op  = w_alu_op;
                if (i_opcode == OP_BRANCH) begin
                    o_ctrl.pc_src   = 1'b1;
                    o_ctrl.pc_write = i_alu_zero;
                end
            end
            ST_MEM: begin
                o_ctrl.alu_src   = w_alu_src;
                o_ctrl.alu_op    = w_alu_op;
                o_ctrl.mem_read  = (i_opcode == OP_LOAD);
                o_ctrl.mem_write = (i_opcode == OP_STORE);
            end
            ST_WB: begin
                o_ctrl.alu_src    = w_alu_src;
                o_ctrl.alu_op     = w_alu_op;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = (i_opcode == OP_LOAD);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: sequences fetch/decode/exec/mem/wb, bounds dmem
// waits with a timeout, and keeps retired-instruction and busy-cycle counters.
module multicycle_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [31:0]      instruction,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);

    localparam int                TMO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [6:0]        r_opcode;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_retired;
    logic [CNT_W-1:0]  r_cycles;
    logic              w_retire;
    logic              w_trap;
    logic              w_busy;
    ctrl_t             w_ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        w_trap       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: w_state_next = ST_DECODE;
            ST_DECODE: begin
                if (instruction == 32'd0) begin
                    w_state_next = ST_HALT;
                end else if (is_legal_op(instruction[6:0])) begin
                    w_state_next = ST_EXEC;
                end else begin
                    w_state_next = ST_ERROR;
                    w_trap       = 1'b1;
                end
            end
            ST_EXEC: begin
                case (r_opcode)
                    OP_LOAD, OP_STORE: w_state_next = ST_MEM;
                    OP_BRANCH: begin
                        w_state_next = ST_FETCH;
                        w_retire     = 1'b1;
                    end
                    default: w_state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    if (r_opcode == OP_LOAD) begin
                        w_state_next = ST_WB;
                    end else begin
                        w_state_next = ST_FETCH;
                        w_retire     = 1'b1;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_state_next = ST_ERROR;
                    w_trap       = 1'b1;
                end
            end
            ST_WB: begin
                w_state_next = ST_FETCH;
                w_retire     = 1'b1;
            end
            default: ;
        endcase
    end

    ctrl_output_decode u_decode (
        .i_state    (r_state),
        .i_opcode   (r_opcode),
        .i_alu_zero (alu_zero),
        .o_ctrl     (w_ctrl)
    );

    // The timeout counter restarts on every entry to MEM and saturates at its limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode <= '0;
            r_tmo    <= '0;
        end else begin
            if (r_state == ST_DECODE) begin
                r_opcode <= instruction[6:0];
            end
            if (r_state == ST_EXEC) begin
                r_tmo <= '0;
            end else if (r_state == ST_MEM && !mem_ready && r_tmo != TMO_LAST) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    assign w_busy = (r_state == ST_FETCH) || (r_state == ST_DECODE) || (r_state == ST_EXEC)
                 || (r_state == ST_MEM) || (r_state == ST_WB);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal <= 1'b0;
            r_retired <= '0;
            r_cycles  <= '0;
        end else begin
            if (w_trap) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
            if (w_busy) begin
                r_cycles <= r_cycles + 1'b1;
            end
        end
    end

    assign ir_write   = w_ctrl.ir_write;
    assign pc_write   = w_ctrl.pc_write;
    assign pc_src     = w_ctrl.pc_src;
    assign alu_src    = w_ctrl.alu_src;
    assign alu_op     = w_ctrl.alu_op;
    assign mem_read   = w_ctrl.mem_read;
    assign mem_write  = w_ctrl.mem_write;
    assign mem_to_reg = w_ctrl.mem_to_reg;
    assign reg_write  = w_ctrl.reg_write;
    assign state      = r_state;
    assign halted     = (r_state == ST_HALT) || (r_state == ST_ERROR);
    assign illegal    = r_illegal;
    assign retired    = r_retired;
    assign cycles     = r_cycles;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a per-instruction model expands each
// instruction into its expected cycle-by-cycle control vectors and counters.
module tb_multicycle_controller;

    localparam int TMO = 4;

    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_IMM = 7'b0010011;
    localparam logic [6:0] T_LD  = 7'b0000011;
    localparam logic [6:0] T_SD  = 7'b0100011;
    localparam logic [6:0] T_BEQ = 7'b1100011;

    typedef struct packed {
        logic [2:0] st;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } ctl_t;

    typedef struct {
        logic [31:0] ins;
        int          delay;
        logic        zero;
        int          exp_cycles;
        int          exp_retired;
        int          exp_term;   // 0 running, 1 halt, 2 error
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] instruction;
    logic        alu_zero;
    logic        mem_ready;
    logic        ir_write, pc_write, pc_src, alu_src;
    logic [1:0]  alu_op;
    logic        mem_read, mem_write, mem_to_reg, reg_write;
    logic [2:0]  state;
    logic        halted, illegal;
    logic [31:0] retired, cycles;

    int n_checks = 0;
    int n_fail   = 0;
    int m_retired;
    int m_cycles;
    bit m_illegal;
    int n_mw;
    int n_rw;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .instruction (instruction),
        .alu_zero    (alu_zero),
        .mem_ready   (mem_ready),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_src     (alu_src),
        .alu_op      (alu_op),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .state       (state),
        .halted      (halted),
        .illegal     (illegal),
        .retired     (retired),
        .cycles      (cycles)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic bit legal_op(input logic [6:0] op);
        return op inside {T_R, T_IMM, T_LD, T_SD, T_BEQ};
    endfunction

    function automatic ctl_t alu_of(input logic [6:0] op, input logic [2:0] st);
        ctl_t e;
        e = '0;
        e.st = st;
        case (op)
            T_R:       begin e.alu_src = 1'b0; e.alu_op = 2'b10; end
            T_IMM:     begin e.alu_src = 1'b1; e.alu_op = 2'b11; end
            T_LD, T_SD: begin e.alu_src = 1'b1; e.alu_op = 2'b00; end
            T_BEQ:     begin e.alu_src = 1'b0; e.alu_op = 2'b01; end
            default: ;
        endcase
        return e;
    endfunction

    // Inputs for this cycle are already driven; compare, then advance one edge.
    task automatic cyc(input ctl_t e, input string nm);
        ctl_t a;
        #1;
        a = {state, ir_write, pc_write, pc_src, alu_src, alu_op,
             mem_read, mem_write, mem_to_reg, reg_write};
        check({nm, "_ctl"}, a, e);
        check({nm, "_halted"}, halted, (e.st >= 3'd6));
        check({nm, "_illegal"}, illegal, m_illegal);
        n_mw += int'(mem_write);
        n_rw += int'(reg_write);
        @(posedge clk);
        #1;
    endtask

    task automatic terminal(input logic [2:0] st);
        ctl_t e;
        e = '0;
        e.st = st;
        run = 1'($urandom);
        mem_ready = 1'($urandom);
        cyc(e, "term");
        check("term_retired", retired, m_retired);
        check("term_cycles", cycles, m_cycles);
        run = ~run;
        cyc(e, "sticky");
        run = 1'b1;
    endtask

    task automatic reset_dut();
        ctl_t e;
        reset = 1'b1; run = 1'b0; instruction = '0; alu_zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_retired = 0; m_cycles = 0; m_illegal = 1'b0;
        e = '0;
        check("rst_retired", retired, 0);
        check("rst_cycles", cycles, 0);
        cyc(e, "reset");
        run = 1'b1;
        cyc(e, "idle");
    endtask

    // Runs one instruction from its FETCH cycle; delay = MEM cycles before mem_ready.
    task automatic instr_run(input logic [31:0] ins, input int delay, input logic zero, output int term);
        ctl_t e;
        logic [6:0] op;
        op = ins[6:0];
        term = 0;
        instruction = ins;
        alu_zero = 1'($urandom); mem_ready = 1'($urandom);
        e = '0; e.st = 3'd1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        cyc(e, "fetch"); m_cycles++;
        alu_zero = 1'($urandom); mem_ready = 1'($urandom);
        e = '0; e.st = 3'd2;
        cyc(e, "decode"); m_cycles++;
        if (ins == 32'd0) begin
            term = 1;
            terminal(3'd6);
        end else if (!legal_op(op)) begin
            m_illegal = 1'b1;
            term = 2;
            terminal(3'd7);
        end else begin
            e = alu_of(op, 3'd3);
            alu_zero = zero; mem_ready = 1'($urandom);
            if (op == T_BEQ) begin
                e.pc_src = 1'b1;
                e.pc_write = zero;
            end
            cyc(e, "exec"); m_cycles++;
            if (op == T_BEQ) m_retired++;
            if (op == T_LD || op == T_SD) begin
                for (int k = 0; k < TMO; k++) begin
                    mem_ready = (k == delay); alu_zero = 1'($urandom);
                    e = alu_of(op, 3'd4);
                    e.mem_read = (op == T_LD);
                    e.mem_write = (op == T_SD);
                    cyc(e, "mem"); m_cycles++;
                    if (k == delay) break;
                end
                if (delay >= TMO) begin
                    m_illegal = 1'b1;
                    term = 2;
                    terminal(3'd7);
                end else if (op == T_SD) begin
                    m_retired++;
                end
            end
            if (term == 0 && (op == T_R || op == T_IMM || op == T_LD)) begin
                mem_ready = 1'($urandom); alu_zero = 1'($urandom);
                e = alu_of(op, 3'd5);
                e.reg_write = 1'b1;
                e.mem_to_reg = (op == T_LD);
                cyc(e, "wb"); m_cycles++; m_retired++;
            end
            if (term == 0) begin
                check("retired", retired, m_retired);
                check("cycles", cycles, m_cycles);
            end
        end
        $display("instr %08h delay=%0d zero=%0d -> state=%0d retired=%0d cycles=%0d term=%0d",
                 ins, delay, zero, state, retired, cycles, term);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[11];
        logic [31:0] prog[6];
        ctl_t        e;
        int          term;
        int          pick;
        logic [31:0] rnd;
        logic [6:0]  op;

        // Single-instruction latencies and terminal outcomes, starting from reset.
        vecs[0]  = '{32'h003100B3, 0, 1'b0, 4, 1, 0};   // add
        vecs[1]  = '{32'h00A00393, 0, 1'b0, 4, 1, 0};   // addi
        vecs[2]  = '{32'h00033283, 0, 1'b0, 5, 1, 0};   // ld, ready at once
        vecs[3]  = '{32'h00033283, 3, 1'b0, 8, 1, 0};   // ld, ready after 3 stalls
        vecs[4]  = '{32'h0072B023, 0, 1'b0, 4, 1, 0};   // sd
        vecs[5]  = '{32'h0072B023, 2, 1'b0, 6, 1, 0};   // sd, 2 stalls
        vecs[6]  = '{32'h0072B023, 99, 1'b0, 7, 0, 2};  // sd, ready stuck low
        vecs[7]  = '{32'h00000463, 0, 1'b1, 3, 1, 0};   // beq taken
        vecs[8]  = '{32'h00000463, 0, 1'b0, 3, 1, 0};   // beq not taken
        vecs[9]  = '{32'h0000007F, 0, 1'b0, 2, 0, 2};   // opcode 1111111
        vecs[10] = '{32'h00000000, 0, 1'b0, 2, 0, 1};   // halt

        n_mw = 0; n_rw = 0;
        for (int i = 0; i < 11; i++) begin
            reset_dut();
            instr_run(vecs[i].ins, vecs[i].delay, vecs[i].zero, term);
            check($sformatf("vec%0d_cycles", i), cycles, vecs[i].exp_cycles);
            check($sformatf("vec%0d_retired", i), retired, vecs[i].exp_retired);
            check($sformatf("vec%0d_halted", i), halted, (vecs[i].exp_term != 0));
            check($sformatf("vec%0d_illegal", i), illegal, (vecs[i].exp_term == 2));
        end

        // Store program ending in the all-zero halt word, mem_ready immediate.
        prog[0] = 32'h00A00393; prog[1] = 32'h01400413; prog[2] = 32'h00500293;
        prog[3] = 32'h0072B023; prog[4] = 32'h0082B423; prog[5] = 32'h00000000;
        reset_dut();
        n_mw = 0; n_rw = 0;
        for (int i = 0; i < 6; i++) begin
            instr_run(prog[i], 0, 1'b0, term);
        end
        check("prog_halted", halted, 1'b1);
        check("prog_retired", retired, 5);
        check("prog_cycles", cycles, 22);   // 3 addi x4 + 2 sd x4 + halt fetch/decode
        check("prog_mem_write_cycles", n_mw, 2);
        check("prog_reg_write_cycles", n_rw, 3);

        // Reset while a store is stalled in MEM.
        reset_dut();
        instruction = 32'h0072B023; alu_zero = 1'b0; mem_ready = 1'b0;
        e = '0; e.st = 3'd1; e.ir_write = 1'b1; e.pc_write = 1'b1;
        cyc(e, "rm_fetch"); m_cycles++;
        e = '0; e.st = 3'd2;
        cyc(e, "rm_decode"); m_cycles++;
        e = alu_of(T_SD, 3'd3);
        cyc(e, "rm_exec"); m_cycles++;
        e = alu_of(T_SD, 3'd4); e.mem_write = 1'b1;
        cyc(e, "rm_mem0");
        reset = 1'b1;
        cyc(e, "rm_mem1");
        reset = 1'b0;
        m_retired = 0; m_cycles = 0; m_illegal = 1'b0;
        check("rm_retired", retired, 0);
        check("rm_cycles", cycles, 0);
        e = '0;
        cyc(e, "rm_idle");
        instr_run(32'h00A00393, 0, 1'b0, term);

        // Random instruction streams against the per-instruction model.
        for (int it = 0; it < 25; it++) begin
            reset_dut();
            term = 0;
            for (int j = 0; j < 6 && term == 0; j++) begin
                pick = $urandom_range(0, 9);
                rnd = $urandom;
                case (pick)
                    0, 1: op = T_R;
                    2, 3: op = T_IMM;
                    4, 5: op = T_LD;
                    6, 7: op = T_SD;
                    8:    op = T_BEQ;
                    default: begin
                        op = 7'($urandom);
                        while (legal_op(op)) op = op + 7'd1;
                        rnd[31] = 1'b1;
                    end
                endcase
                instr_run({rnd[31:7], op}, $urandom_range(0, 5), 1'($urandom), term);
            end
            if (term == 0) instr_run(32'd0, 0, 1'b0, term);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
